// File: rtl/territory_tally_pkg.sv
// Shared constants, colour codes, address packing and state encoding for the
// end-of-round territory counter.
package territory_tally_pkg;

   // Board geometry in pixels
   localparam int BOARD_X_MAX = 160;
   localparam int BOARD_Y_MAX = 120;

   // Pixel colour codes stored in the 3-bit board RAM
   localparam logic [2:0] P1_COL    = 3'b001;
   localparam logic [2:0] P2_COL    = 3'b010;
   localparam logic [2:0] P3_COL    = 3'b100;
   localparam logic [2:0] P4_COL    = 3'b110;
   localparam logic [2:0] TIMER_COL = 3'b111;

   // Sweep controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SWEEP  = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_DECIDE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Board RAM address layout: x in the upper byte, y in the low 7 bits
   function automatic logic [14:0] pack_addr(input logic [7:0] i_x, input logic [6:0] i_y);
      return {i_x, i_y};
   endfunction

   // One-hot player hit for a pixel value; timer bar and background count for nobody
   function automatic logic [3:0] classify(input logic [2:0] i_q);
      logic [3:0] w_onehot;
      case (i_q)
         P1_COL:    w_onehot = 4'b0001;
         P2_COL:    w_onehot = 4'b0010;
         P3_COL:    w_onehot = 4'b0100;
         P4_COL:    w_onehot = 4'b1000;
         TIMER_COL: w_onehot = 4'b0000;
         default:   w_onehot = 4'b0000;
      endcase
      return w_onehot;
   endfunction

endpackage

// File: rtl/territory_tally_compare.sv
// Four-way maximum with lowest-index priority; flags a tie when more than
// one player reaches the maximum (all-zero counts are therefore a tie).
module tally_compare
   import territory_tally_pkg::*;
(
   input  logic [14:0] i_c0,
   input  logic [14:0] i_c1,
   input  logic [14:0] i_c2,
   input  logic [14:0] i_c3,
   output logic [1:0]  o_winner,
   output logic        o_tie
);

   logic [14:0] w_max;
   logic [2:0]  w_hits;

   // Find the maximum, the first index reaching it, and how many reach it
   always_comb begin
      w_max = i_c0;
      if (i_c1 > w_max) w_max = i_c1;
      else              w_max = w_max;
      if (i_c2 > w_max) w_max = i_c2;
      else              w_max = w_max;
      if (i_c3 > w_max) w_max = i_c3;
      else              w_max = w_max;

      o_winner = 2'd0;
      if (i_c0 == w_max)      o_winner = 2'd0;
      else if (i_c1 == w_max) o_winner = 2'd1;
      else if (i_c2 == w_max) o_winner = 2'd2;
      else                    o_winner = 2'd3;

      w_hits = {2'b00, (i_c0 == w_max)} + {2'b00, (i_c1 == w_max)}
             + {2'b00, (i_c2 == w_max)} + {2'b00, (i_c3 == w_max)};
      o_tie  = (w_hits > 3'd1);
   end

endmodule

// File: rtl/territory_tally.sv
// End-of-round territory counter: sweeps every board pixel through the RAM
// read port, tallies each player's colour and publishes counts, winner, tie.
module territory_tally
   import territory_tally_pkg::*;
#(
   parameter int X_MAX        = BOARD_X_MAX,
   parameter int Y_MAX        = BOARD_Y_MAX,
   parameter int READ_LATENCY = 1
)(
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   output logic [14:0] address,
   output logic        rd_en,
   input  logic [2:0]  q,
   output logic        busy,
   output logic        done,
   output logic [14:0] p1_count,
   output logic [14:0] p2_count,
   output logic [14:0] p3_count,
   output logic [14:0] p4_count,
   output logic [1:0]  winner,
   output logic        tie
);

   localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
   localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [14:0]             r_address;
   logic                    r_rd_en;
   logic                    r_busy;
   logic                    r_done;
   logic [READ_LATENCY-1:0] r_vpipe;
   logic [14:0]             r_cnt1, r_cnt2, r_cnt3, r_cnt4;
   logic [14:0]             r_pub1, r_pub2, r_pub3, r_pub4;
   logic [1:0]              r_winner;
   logic                    r_tie;
   logic [1:0]              w_winner;
   logic                    w_tie;
   logic [7:0]              w_x;
   logic [6:0]              w_y;
   logic                    w_last;
   logic                    w_start_ok;
   logic                    w_q_valid;
   logic [3:0]              w_hit;

   // The issued address doubles as the sweep position
   assign w_x        = r_address[14:7];
   assign w_y        = r_address[6:0];
   assign w_last     = (w_x == X_LAST) && (w_y == Y_LAST);
   assign w_start_ok = (r_state == ST_IDLE) && start;
   assign w_q_valid  = r_vpipe[READ_LATENCY-1];
   assign w_hit      = classify(q) & {4{w_q_valid}};

   tally_compare u_compare (
      .i_c0     (r_cnt1),
      .i_c1     (r_cnt2),
      .i_c2     (r_cnt3),
      .i_c3     (r_cnt4),
      .o_winner (w_winner),
      .o_tie    (w_tie)
   );

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic; start is only honoured in IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_next = ST_SWEEP;
            else       w_state_next = ST_IDLE;
         end
         ST_SWEEP: begin
            if (w_last) w_state_next = ST_DRAIN;
            else        w_state_next = ST_SWEEP;
         end
         ST_DRAIN: begin
            if (r_vpipe == {READ_LATENCY{1'b0}}) w_state_next = ST_DECIDE;
            else                                 w_state_next = ST_DRAIN;
         end
         ST_DECIDE: w_state_next = ST_DONE;
         ST_DONE:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Address generator: y inner loop, x outer; bus held at zero outside the sweep
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_address <= 15'd0;
         r_rd_en   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_address <= pack_addr(8'd0, 7'd0);
               r_rd_en   <= start;
            end
            ST_SWEEP: begin
               if (w_last) begin
                  r_address <= 15'd0;
                  r_rd_en   <= 1'b0;
               end else if (w_y == Y_LAST) begin
                  r_address <= pack_addr(w_x + 8'd1, 7'd0);
                  r_rd_en   <= 1'b1;
               end else begin
                  r_address <= pack_addr(w_x, w_y + 7'd1);
                  r_rd_en   <= 1'b1;
               end
            end
            default: begin
               r_address <= 15'd0;
               r_rd_en   <= 1'b0;
            end
         endcase
      end
   end

   // busy and done are registered views of the upcoming state
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_next != ST_IDLE);
         r_done <= (w_state_next == ST_DONE);
      end
   end

   // Valid pipeline tracking which RAM responses belong to sweep addresses
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_vpipe <= {READ_LATENCY{1'b0}};
      end else begin
         r_vpipe[0] <= r_rd_en;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
      end
   end

   // Working counters: cleared on an accepted start, bumped per classified pixel
   always_ff @(posedge CLOCK_50) begin
      if (reset || w_start_ok) begin
         r_cnt1 <= 15'd0;
         r_cnt2 <= 15'd0;
         r_cnt3 <= 15'd0;
         r_cnt4 <= 15'd0;
      end else begin
         r_cnt1 <= r_cnt1 + {14'd0, w_hit[0]};
         r_cnt2 <= r_cnt2 + {14'd0, w_hit[1]};
         r_cnt3 <= r_cnt3 + {14'd0, w_hit[2]};
         r_cnt4 <= r_cnt4 + {14'd0, w_hit[3]};
      end
   end

   // Published results: loaded on leaving DECIDE so they are valid alongside done
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_pub1   <= 15'd0;
         r_pub2   <= 15'd0;
         r_pub3   <= 15'd0;
         r_pub4   <= 15'd0;
         r_winner <= 2'd0;
         r_tie    <= 1'b0;
      end else if (r_state == ST_DECIDE) begin
         r_pub1   <= r_cnt1;
         r_pub2   <= r_cnt2;
         r_pub3   <= r_cnt3;
         r_pub4   <= r_cnt4;
         r_winner <= w_winner;
         r_tie    <= w_tie;
      end else begin
         r_pub1   <= r_pub1;
         r_pub2   <= r_pub2;
         r_pub3   <= r_pub3;
         r_pub4   <= r_pub4;
         r_winner <= r_winner;
         r_tie    <= r_tie;
      end
   end

   assign address  = r_address;
   assign rd_en    = r_rd_en;
   assign busy     = r_busy;
   assign done     = r_done;
   assign p1_count = r_pub1;
   assign p2_count = r_pub2;
   assign p3_count = r_pub3;
   assign p4_count = r_pub4;
   assign winner   = r_winner;
   assign tie      = r_tie;

endmodule

// File: tb/tb_territory_tally.sv
// Bench for territory_tally: two instances (read latency 1 and 3) each with
// its own board RAM model; a scoreboard holds reference results per sweep.
module tb_territory_tally;

   localparam int RLAT [2] = '{1, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic [14:0] addr  [2];
   logic        rd    [2];
   logic [2:0]  qd    [2];
   logic        bsy   [2];
   logic        dn    [2];
   logic [14:0] c1    [2];
   logic [14:0] c2    [2];
   logic [14:0] c3    [2];
   logic [14:0] c4    [2];
   logic [1:0]  win   [2];
   logic        tie_o [2];

   territory_tally #(.X_MAX(160), .Y_MAX(120), .READ_LATENCY(1)) u_dut1 (
      .CLOCK_50(clk), .reset(reset), .start(start), .address(addr[0]), .rd_en(rd[0]),
      .q(qd[0]), .busy(bsy[0]), .done(dn[0]), .p1_count(c1[0]), .p2_count(c2[0]),
      .p3_count(c3[0]), .p4_count(c4[0]), .winner(win[0]), .tie(tie_o[0]));

   territory_tally #(.X_MAX(160), .Y_MAX(120), .READ_LATENCY(3)) u_dut3 (
      .CLOCK_50(clk), .reset(reset), .start(start), .address(addr[1]), .rd_en(rd[1]),
      .q(qd[1]), .busy(bsy[1]), .done(dn[1]), .p1_count(c1[1]), .p2_count(c2[1]),
      .p3_count(c3[1]), .p4_count(c4[1]), .winner(win[1]), .tie(tie_o[1]));

   // Board RAM models
   logic [2:0] mem0 [0:32767];
   logic [2:0] mem1 [0:32767];
   logic [2:0] rp0, rp1a, rp1b, rp1c;
   always @(posedge clk) begin
      rp0  <= mem0[addr[0]];
      rp1a <= mem1[addr[1]];
      rp1b <= rp1a;
      rp1c <= rp1b;
   end
   assign qd[0] = rp0;
   assign qd[1] = rp1c;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c1; int c2; int c3; int c4; int w; int t; int st;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input bit ok, input string name, input int d, input int act, input int req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL dut%0d %s: got %0d, expected %0d", d, name, act, req);
   endtask

   // Pattern generator over the visible board
   task automatic fill(input int d, input int pat);
      logic [2:0] v;
      for (int a = 0; a < 32768; a++) begin
         if (d == 0) mem0[a] = 3'd0;
         else        mem1[a] = 3'd0;
      end
      for (int x = 0; x < 160; x++) begin
         for (int y = 0; y < 120; y++) begin
            case (pat)
               1: v = (x < 40) ? 3'b001 : (x < 80) ? 3'b010 : (x < 120) ? 3'b100 :
                      (x == 159) ? 3'b000 : 3'b110;
               2: v = (x == 159 && y == 119) ? 3'b110 : 3'b000;
               3: v = (y == 119) ? 3'b111 : 3'b010;
               4: v = 3'($urandom_range(0, 7));
               default: v = 3'b000;
            endcase
            if (d == 0) mem0[x*128 + y] = v;
            else        mem1[x*128 + y] = v;
         end
      end
   endtask

   // Reference: plain per-colour tally over the board, then max/winner/tie
   task automatic model(input int d, output exp_t e);
      int n [4];
      int mx, nmax;
      logic [2:0] v;
      n = '{0, 0, 0, 0};
      for (int x = 0; x < 160; x++) begin
         for (int y = 0; y < 120; y++) begin
            v = (d == 0) ? mem0[x*128 + y] : mem1[x*128 + y];
            if (v == 3'b001) n[0]++;
            else if (v == 3'b010) n[1]++;
            else if (v == 3'b100) n[2]++;
            else if (v == 3'b110) n[3]++;
         end
      end
      mx = 0;
      for (int i = 0; i < 4; i++) if (n[i] > mx) mx = n[i];
      e.w  = -1;
      nmax = 0;
      for (int i = 0; i < 4; i++) begin
         if (n[i] == mx) begin
            nmax++;
            if (e.w < 0) e.w = i;
         end
      end
      e.t  = (nmax > 1) ? 1 : 0;
      e.c1 = n[0]; e.c2 = n[1]; e.c3 = n[2]; e.c4 = n[3];
      e.st = 0;
   endtask

   // Monitor state
   int   n_iss [2];
   int   bad_a [2];
   int   ex    [2];
   int   ey    [2];
   int   last_a[2];
   int   bad_h [2];
   bit   prev_dn [2];
   exp_t held  [2];
   exp_t e_m;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            n_iss[d] = 0; bad_a[d] = 0; ex[d] = 0; ey[d] = 0; last_a[d] = 0; bad_h[d] = 0;
            prev_dn[d] = 0;
            held[d] = '{0, 0, 0, 0, 0, 0, 0};
         end else begin
            if (prev_dn[d]) chk(!dn[d] && !bsy[d], "done_pulse_then_idle", d,
                                int'(dn[d]) + 2*int'(bsy[d]), 0);
            prev_dn[d] = dn[d];
            if (!bsy[d] && (addr[d] != 15'd0 || rd[d])) bad_a[d]++;
            if (rd[d]) begin
               if (int'(addr[d]) != ex[d]*128 + ey[d]) bad_a[d]++;
               if (addr[d][14:7] >= 8'd160 || addr[d][6:0] >= 7'd120) bad_a[d]++;
               last_a[d] = int'(addr[d]);
               n_iss[d]++;
               ey[d]++;
               if (ey[d] == 120) begin ey[d] = 0; ex[d]++; end
            end
            if (dn[d]) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  chk(1'b0, "unexpected_done", d, cyc, 0);
               end else begin
                  if (d == 0) e_m = q0.pop_front();
                  else        e_m = q1.pop_front();
                  chk(int'(c1[d]) == e_m.c1, "p1_count", d, int'(c1[d]), e_m.c1);
                  chk(int'(c2[d]) == e_m.c2, "p2_count", d, int'(c2[d]), e_m.c2);
                  chk(int'(c3[d]) == e_m.c3, "p3_count", d, int'(c3[d]), e_m.c3);
                  chk(int'(c4[d]) == e_m.c4, "p4_count", d, int'(c4[d]), e_m.c4);
                  chk(int'(win[d]) == e_m.w, "winner", d, int'(win[d]), e_m.w);
                  chk(int'(tie_o[d]) == e_m.t, "tie", d, int'(tie_o[d]), e_m.t);
                  chk(cyc - e_m.st == 19202 + RLAT[d], "done_latency", d, cyc - e_m.st,
                      19202 + RLAT[d]);
                  chk(n_iss[d] == 19200, "addresses_issued", d, n_iss[d], 19200);
                  chk(last_a[d] == 159*128 + 119, "last_address", d, last_a[d], 159*128 + 119);
                  chk(bad_a[d] == 0, "address_errors", d, bad_a[d], 0);
                  chk(bad_h[d] == 0, "outputs_held_while_busy", d, bad_h[d], 0);
                  held[d] = e_m;
               end
               n_iss[d] = 0; bad_a[d] = 0; ex[d] = 0; ey[d] = 0; bad_h[d] = 0;
            end else if (bsy[d]) begin
               if (int'(c1[d]) != held[d].c1 || int'(c2[d]) != held[d].c2 ||
                   int'(c3[d]) != held[d].c3 || int'(c4[d]) != held[d].c4 ||
                   int'(win[d]) != held[d].w || int'(tie_o[d]) != held[d].t) bad_h[d]++;
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk(addr[d] == 15'd0, {tag, "_address"}, d, int'(addr[d]), 0);
         chk(rd[d] == 1'b0, {tag, "_rd_en"}, d, int'(rd[d]), 0);
         chk(bsy[d] == 1'b0, {tag, "_busy"}, d, int'(bsy[d]), 0);
         chk(dn[d] == 1'b0, {tag, "_done"}, d, int'(dn[d]), 0);
         chk(c1[d] == 15'd0 && c2[d] == 15'd0 && c3[d] == 15'd0 && c4[d] == 15'd0,
             {tag, "_counts_sum"}, d, int'(c1[d]) + int'(c2[d]) + int'(c3[d]) + int'(c4[d]), 0);
         chk(win[d] == 2'd0, {tag, "_winner"}, d, int'(win[d]), 0);
         chk(tie_o[d] == 1'b0, {tag, "_tie"}, d, int'(tie_o[d]), 0);
      end
   endtask

   task automatic run_sweep(input int pat0, input int pat1, input bit spam);
      exp_t e0, e1;
      bit   s0, s1, first0;
      fill(0, pat0);
      fill(1, pat1);
      model(0, e0);
      model(1, e1);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      e0.st = cyc;
      e1.st = cyc;
      q0.push_back(e0);
      q1.push_back(e1);
      s0 = 1'b0;
      s1 = 1'b0;
      for (int k = 0; k < 20000 && !(s0 && s1); k++) begin
         @(posedge clk); #1;
         first0 = dn[0] && !s0;
         if (dn[0]) s0 = 1'b1;
         if (dn[1]) s1 = 1'b1;
         start = spam && ((k == 1) || first0 ||
                          (k < 19000 && $urandom_range(0, 1999) == 0));
      end
      start = 1'b0;
      chk(s0 && s1, "sweep_complete", 0, int'(s0) + 2*int'(s1), 3);
      repeat (3) @(posedge clk);
      #1;
      chk(!bsy[0] && !bsy[1], "idle_after_sweep", 0, int'(bsy[0]) + 2*int'(bsy[1]), 0);
   endtask

   task automatic abort_sweep();
      fill(0, 4);
      fill(1, 4);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4999) @(posedge clk);
      #1;
      chk(bsy[0] && bsy[1] && rd[0] && rd[1], "busy_mid_sweep", 0,
          int'(bsy[0]) + int'(bsy[1]) + int'(rd[0]) + int'(rd[1]), 4);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check_reset_state("after_abort");
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b0;
      run_sweep(0, 1, 1'b0);
      run_sweep(1, 3, 1'b0);
      abort_sweep();
      run_sweep(2, 4, 1'b1);
      chk(q0.size() == 0 && q1.size() == 0, "scoreboard_drained", 0,
          q0.size() + q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/territory_tally.md
Name: territory_tally

Overview:
- Reader-side counterpart to the per-frame player plotting logic. When the round ends, it sweeps the 3-bit board RAM and counts the pixels owned by each player colour.
- Reports per-player territory counts, the winner index and a tie flag to the HEX/score logic.
- Sits between the board RAM read port and the end-of-round display logic. Owns the RAM address bus only while busy.

Parameters:
- X_MAX, 160, board width in pixels (x range 0..X_MAX-1).
- Y_MAX, 120, board height in pixels (y range 0..Y_MAX-1).
- READ_LATENCY, 1, cycles from address presented to q valid (1..3 supported).

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- address  out  15  board RAM address, {x[7:0], y[6:0]}.
- rd_en  out  1  high while address carries a valid sweep address.
- q  in  3  RAM read data, READ_LATENCY cycles after address.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results become valid.
- p1_count, p2_count, p3_count, p4_count  out  15 each  owned-pixel counts.
- winner  out  2  index of the winning player (0 = P1 .. 3 = P4).
- tie  out  1  high if two or more players share the maximum count.

Behaviour:
- Reset values: address 0, rd_en 0, busy 0, done 0, all counts 0, winner 0, tie 0; state IDLE.
- States: IDLE -> SWEEP -> DRAIN -> DECIDE -> DONE -> IDLE.
- IDLE:
  - start=1 clears the working counters, loads x=0, y=0 and enters SWEEP.
  - Published outputs hold their previous results until DONE.
- SWEEP:
  - rd_en=1; one address is issued per cycle.
  - y is the inner loop: 0..Y_MAX-1. At y=Y_MAX-1, y wraps to 0 and x increments.
  - Addresses with x>=X_MAX or y>=Y_MAX are never issued.
  - After address {X_MAX-1, Y_MAX-1} is issued, go to DRAIN; exactly X_MAX*Y_MAX = 19200 addresses.
- Valid pipeline: a READ_LATENCY-deep shift register of rd_en. When its tail is 1, q is classified:
  - 3'b001 increments P1.
  - 3'b010 increments P2.
  - 3'b100 increments P3.
  - 3'b110 increments P4.
  - Every other value (background 000, timer bar 111, others) is ignored.
- DRAIN: rd_en=0. Stay until the valid pipeline is empty, then go to DECIDE.
- DECIDE (1 cycle):
  - Compute the maximum of the four counts.
  - winner = lowest index achieving the maximum.
  - tie = 1 if more than one index achieves it; all counts zero gives winner 0, tie 1.
- DONE (1 cycle):
  - Publish counts, winner and tie to the outputs; done=1; busy=0 in the following cycle.
  - Return to IDLE.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E0 + 19200 + READ_LATENCY + 2. Results are stable from that cycle until the next DONE.
- start while busy: ignored; no restart, no error.
- start in the same cycle as DONE: ignored; it is taken only in IDLE.
- reset mid-sweep: immediate return to IDLE, rd_en 0, all outputs return to reset values on the next edge.
- Arithmetic: 15-bit unsigned counters with no wrap, since the maximum of 19200 is below 32767. No saturation logic is required.
- address is driven 0 when not busy, so the top-level mux is clean.

Decomposition:
- Shared package holds:
  - colour codes P1_COL=3'b001, P2_COL=3'b010, P3_COL=3'b100, P4_COL=3'b110, TIMER_COL=3'b111;
  - X_MAX/Y_MAX board constants;
  - the address packing {x[7:0], y[6:0]};
  - state encoding.
- One sub-module, tally_compare: combinational 4-way max with lowest-index priority and tie detection, used in DECIDE.

Test Plan:
- All-zero RAM model, READ_LATENCY=1, start -> done exactly 19203 cycles after the start edge; counts 0/0/0/0, winner 0, tie 1.
- RAM column x<40 = 001, 40..79 = 010, 80..119 = 100, 120..159 = 110, except column 159 = 000 -> counts 4800/4800/4800/4680, winner 0, tie 1.
- Single pixel {x=159, y=119} = 110, rest 000 -> p4_count 1, winner 3, tie 0. Check this is the last address issued and that no address has y>=120.
- Row y=119 all 111, rest 010 -> p2_count 19040, others 0, winner 1, tie 0.
- Mid-sweep: start, then reset at cycle 5000 -> all outputs 0, rd_en 0. A second start yields a full correct result; start pulses issued while busy cause no restart.
- READ_LATENCY=3 with the pattern from the second scenario -> identical counts; done at 19205 cycles; all 19200 responses are counted.
